// File: rtl/jb_aes_pkg.sv
// AES shared definitions: block width, state layout, S-box, round constants, GF(2^8) helpers.
// Used by both the encrypt and decrypt datapaths.
// State layout: aes_state_t[row][col]; byte (r,c) sits at bits [127-8*(4r+c) -: 8].
package jb_aes_pkg;

  localparam int AES_BLOCK_WIDTH = 128;

  typedef logic [0:3][0:3][7:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants for key-expansion rounds 1..10.
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/jb_aes_enc_round.sv
// One AES encryption round, purely combinational.
// Ports: state_in/round_key (128b, row-major), final_round skips MixColumns, state_out (128b).
// Order: SubBytes -> ShiftRows -> MixColumns (unless final) -> AddRoundKey.
module jb_aes_enc_round
  import jb_aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  aes_state_t s_in;
  aes_state_t rk;
  aes_state_t sb;
  aes_state_t sr;
  aes_state_t mc;

  always_comb begin
    s_in = state_in;
    rk   = round_key;
    sb   = '0;
    sr   = '0;
    mc   = '0;

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sb[r][c] = SBOX[s_in[r][c]];
      end
    end

    // Row r rotates left by r; the 2-bit cast wraps the column index.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r][c] = sb[r][2'(c + r)];
      end
    end

    // Column mix with matrix rows {2,3,1,1} rotated; 3*a = xtime(a)^a.
    for (int c = 0; c < 4; c++) begin
      mc[0][c] = xtime(sr[0][c]) ^ xtime(sr[1][c]) ^ sr[1][c] ^ sr[2][c] ^ sr[3][c];
      mc[1][c] = sr[0][c] ^ xtime(sr[1][c]) ^ xtime(sr[2][c]) ^ sr[2][c] ^ sr[3][c];
      mc[2][c] = sr[0][c] ^ sr[1][c] ^ xtime(sr[2][c]) ^ xtime(sr[3][c]) ^ sr[3][c];
      mc[3][c] = xtime(sr[0][c]) ^ sr[0][c] ^ sr[1][c] ^ sr[2][c] ^ xtime(sr[3][c]);
    end

    state_out = (final_round ? sr : mc) ^ rk;
  end

endmodule

// File: rtl/jb_aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Ports: clk, rst (async high), nStart (active-low start), key/blockin (sampled at start),
//        blockout (registered ciphertext), nDone (one-cycle low strobe), busy (RUN state).
module jb_aes_encrypt_iter
  import jb_aes_pkg::*;
#(
  parameter int BLOCK_WIDTH = AES_BLOCK_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   nStart,
  input  logic [BLOCK_WIDTH-1:0] key,
  input  logic [BLOCK_WIDTH-1:0] blockin,
  output logic [BLOCK_WIDTH-1:0] blockout,
  output logic                   nDone,
  output logic                   busy
);

  if (BLOCK_WIDTH != AES_BLOCK_WIDTH) begin : g_bad_width
    $error("jb_aes_encrypt_iter: BLOCK_WIDTH must be 128");
  end

  enc_state_e             state_q, state_d;
  logic [BLOCK_WIDTH-1:0] blk_q, blk_d;
  logic [BLOCK_WIDTH-1:0] rk_q, rk_d;
  logic [3:0]             rnd_q, rnd_d;
  logic [BLOCK_WIDTH-1:0] blockout_q, blockout_d;
  logic                   ndone_q, ndone_d;

  aes_state_t             rk_cur;
  aes_state_t             rk_nxt;
  logic [0:3][7:0]        tw;
  logic [7:0]             rcon_b;
  logic [BLOCK_WIDTH-1:0] round_out;

  // Key expansion: derive round key rnd_q from the previous one held in rk_q.
  always_comb begin
    rk_cur = rk_q;
    rk_nxt = '0;
    tw     = '0;
    rcon_b = 8'h00;
    if (rnd_q >= 4'd1 && rnd_q <= 4'd10) begin
      rcon_b = RCON[rnd_q];
    end
    // RotWord + SubWord of the last column, then rcon into the top byte.
    for (int r = 0; r < 4; r++) begin
      tw[r] = SBOX[rk_cur[2'(r + 1)][3]];
    end
    tw[0] = tw[0] ^ rcon_b;
    for (int r = 0; r < 4; r++) begin
      rk_nxt[r][0] = rk_cur[r][0] ^ tw[r];
      for (int c = 1; c < 4; c++) begin
        rk_nxt[r][c] = rk_nxt[r][c-1] ^ rk_cur[r][c];
      end
    end
  end

  jb_aes_enc_round u_round (
    .state_in    (blk_q),
    .round_key   (rk_nxt),
    .final_round (rnd_q == 4'd10),
    .state_out   (round_out)
  );

  // Next-state / datapath control.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    rk_d       = rk_q;
    rnd_d      = rnd_q;
    blockout_d = blockout_q;
    ndone_d    = 1'b1;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (!nStart) begin
          blk_d   = blockin ^ key;
          rk_d    = key;
          rnd_d   = 4'd1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // nStart is deliberately not looked at here: no queuing of requests.
        blk_d = round_out;
        rk_d  = rk_nxt;
        if (rnd_q == 4'd10) begin
          blockout_d = round_out;
          ndone_d    = 1'b0;
          rnd_d      = 4'd0;
          state_d    = ST_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      blk_q      <= '0;
      rk_q       <= '0;
      rnd_q      <= 4'd0;
      blockout_q <= '0;
      ndone_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      rk_q       <= rk_d;
      rnd_q      <= rnd_d;
      blockout_q <= blockout_d;
      ndone_q    <= ndone_d;
    end
  end

  assign blockout = blockout_q;
  assign nDone    = ndone_q;
  assign busy     = (state_q == ST_RUN);

endmodule

// File: doc/jb_aes_encrypt_iter.md
JB_AES_ENCRYPT_ITER -- requirements
Module: jb_aes_encrypt_iter

Interface
REQ-001 The block SHALL run on one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-002 Parameter BLOCK_WIDTH, default 128, AES block/key width in bits; only 128 SHALL be legal, with an elaboration error otherwise.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 nStart  input  1  active-low start request, sampled at the rising edge of clk.
REQ-006 key  input  BLOCK_WIDTH  AES-128 cipher key, sampled only at an accepted start.
REQ-007 blockin  input  BLOCK_WIDTH  plaintext block, sampled only at an accepted start.
REQ-008 blockout  output  BLOCK_WIDTH  ciphertext, registered.
REQ-009 nDone  output  1  active-low one-cycle completion strobe, registered.
REQ-010 busy  output  1  high while a block is in progress (RUN state).
REQ-011 Byte packing SHALL be row-major: state byte (row r, col c) occupies bits [127-8*(4r+c) -: 8] of key, blockin and blockout.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, nStart==0 at an edge SHALL be accepted: state <= blockin ^ key, round key <= key, round counter <= 1, next state RUN.
REQ-014 In RUN, each edge SHALL apply one AES round using the on-the-fly expanded round key; rounds 1-9 SHALL be SubBytes, ShiftRows, MixColumns, AddRoundKey.
REQ-015 Round 10 SHALL omit MixColumns, load blockout with the result and move to DONE.
REQ-016 Round-key expansion SHALL use rcon 01,02,04,08,10,20,40,80,1b,36 for rounds 1-10, with GF(2^8) reduction polynomial 0x11b.
REQ-017 Latency: for a start accepted at edge E0, blockout and nDone==0 SHALL become valid after edge E10, and nDone SHALL return to 1 after E11 unless a new block completes.
REQ-018 nDone SHALL be low only in DONE, for exactly one cycle per completed block.
REQ-019 blockout SHALL hold its value until the next completion.
REQ-020 nStart==0 during RUN SHALL be ignored, with no queuing.
REQ-021 A start accepted in DONE SHALL give back-to-back throughput of one block per 11 cycles.
REQ-022 key and blockin changes after acceptance SHALL NOT affect the block in progress.
REQ-023 busy SHALL equal (state==RUN).
REQ-024 With nStart held low continuously, a new block SHALL start in each IDLE or DONE cycle.

Reset
REQ-025 On rst assertion the block SHALL immediately enter IDLE with blockout=0, nDone=1, busy=0, round counter=0, and internal state and key registers cleared.
REQ-026 A reset during RUN SHALL abort the block without any nDone pulse.
REQ-027 The first start SHALL be accepted at the first edge after rst deasserts.

Structure
REQ-028 Shared package jb_aes_pkg SHALL hold the BLOCK_WIDTH constant, the state typedef logic [0:3][0:3][7:0], the S-box constant table, the rcon table and the xtime function, all shared with the decrypt path.
REQ-029 One combinational sub-module, jb_aes_enc_round, SHALL implement one round with a final-round flag input; key expansion SHALL stay in the top module.

Verification
REQ-030 Test 1: key 0004080c0105090d02060a0e03070b0f, blockin 004488cc115599dd2266aaee3377bbff, nStart low one cycle -> blockout 696ad870c47bcdb4e004b7c5d830805a with nDone low exactly 10 edges after acceptance, for one cycle.
REQ-031 Test 2: key 2b28ab097eaef7cf15d2154f16a6883c, blockin 328831e0435a3137f6309807a88da234 -> blockout 3902dc1925dc116a8409850b1dfb9732.
REQ-032 Test 3: pulse nStart low again at RUN cycle 5 and change key/blockin -> result equals the Test 2 value, with a single nDone pulse.
REQ-033 Test 4: hold nStart low with the Test 1 inputs -> nDone pulses every 11 cycles and busy is low only in DONE cycles.
REQ-034 Test 5: assert rst at RUN cycle 4 -> immediately nDone=1, busy=0, blockout=0 with no later pulse; rerunning Test 1 then passes.
